// File: rtl/rename_dispatch_pkg.sv
// Shared types for the rename/dispatch stage: the packed reservation-station entry,
// station index constants and the dispatch register state encoding.
package rename_dispatch_pkg;

  localparam int unsigned ArchRegW = 5;
  localparam int unsigned PhysRegW = 6;
  localparam int unsigned RobIdxW  = 5;
  localparam int unsigned NumRs    = 4;
  localparam int unsigned UopW     = 64;
  localparam int unsigned FuW      = 2;

  localparam logic [FuW-1:0] FuInt    = 2'd0;
  localparam logic [FuW-1:0] FuMulDiv = 2'd1;
  localparam logic [FuW-1:0] FuBranch = 2'd2;
  localparam logic [FuW-1:0] FuMem    = 2'd3;

  typedef struct packed {
    logic [UopW-1:0]     payload;
    logic [PhysRegW-1:0] prs1;
    logic                prs1_rdy;
    logic [PhysRegW-1:0] prs2;
    logic                prs2_rdy;
    logic [PhysRegW-1:0] prd;
    logic [RobIdxW-1:0]  rob_idx;
    logic [FuW-1:0]      fu;
  } dispatch_entry_t;

  typedef enum logic {StEmpty, StHeld} disp_state_e;

endpackage

// File: rtl/operand_wakeup.sv
// Operand readiness update: a source becomes ready when the CDB broadcasts its preg.
module operand_wakeup #(
  parameter int unsigned PHYS_REG_WIDTH = 6
) (
  input  logic [PHYS_REG_WIDTH-1:0] preg,
  input  logic                      rdy_in,
  input  logic                      cdb_valid,
  input  logic [PHYS_REG_WIDTH-1:0] cdb_preg,
  output logic                      rdy_out
);

  assign rdy_out = rdy_in | (cdb_valid & (cdb_preg == preg));

endmodule

// File: rtl/rename_dispatch.sv
// Rename and dispatch stage: renames one uop per cycle into a single dispatch register
// that snoops the CDB and pushes into the selected reservation station.
module rename_dispatch
  import rename_dispatch_pkg::*;
#(
  parameter int unsigned ARCH_REG_WIDTH = ArchRegW,
  parameter int unsigned PHYS_REG_WIDTH = PhysRegW,
  parameter int unsigned ROB_IDX_WIDTH  = RobIdxW,
  parameter int unsigned NUM_RS         = NumRs,
  parameter int unsigned UOP_WIDTH      = UopW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ARCH_REG_WIDTH-1:0] in_rs1,
  input  logic [ARCH_REG_WIDTH-1:0] in_rs2,
  input  logic [ARCH_REG_WIDTH-1:0] in_rd,
  input  logic                      in_rd_we,
  input  logic [FuW-1:0]            in_fu,
  input  logic [UOP_WIDTH-1:0]      in_payload,
  output logic [ARCH_REG_WIDTH-1:0] rat_rs1_addr,
  output logic [ARCH_REG_WIDTH-1:0] rat_rs2_addr,
  input  logic [PHYS_REG_WIDTH-1:0] rat_rs1_preg,
  input  logic [PHYS_REG_WIDTH-1:0] rat_rs2_preg,
  input  logic                      rat_rs1_rdy,
  input  logic                      rat_rs2_rdy,
  output logic                      rat_wen,
  output logic [ARCH_REG_WIDTH-1:0] rat_ard,
  output logic [PHYS_REG_WIDTH-1:0] rat_prd,
  input  logic                      fl_empty,
  input  logic [PHYS_REG_WIDTH-1:0] fl_preg,
  output logic                      fl_pop,
  input  logic                      rob_full,
  output logic                      rob_alloc,
  output logic [ARCH_REG_WIDTH-1:0] rob_ard,
  output logic [PHYS_REG_WIDTH-1:0] rob_prd,
  input  logic [ROB_IDX_WIDTH-1:0]  rob_idx,
  input  logic [NUM_RS-1:0]         rs_full,
  output logic [NUM_RS-1:0]         rs_push,
  output dispatch_entry_t           rs_entry,
  input  logic                      cdb_valid,
  input  logic [PHYS_REG_WIDTH-1:0] cdb_preg,
  input  logic                      flush,
  output logic [31:0]               stall_cycles
);

  disp_state_e     state_q, state_d;
  dispatch_entry_t entry_q, cap_entry, held_view;

  logic                      held, alloc_need, dispatch_fire, push_fire, ready_int, accept;
  logic [PHYS_REG_WIDTH-1:0] src1_preg, src2_preg;
  logic                      cap_rs1_rdy, cap_rs2_rdy, held_rs1_rdy, held_rs2_rdy;

  assign held          = (state_q == StHeld);
  assign alloc_need    = in_rd_we & (in_rd != '0);
  assign dispatch_fire = held & ~rs_full[entry_q.fu];
  assign push_fire     = rst & ~flush & dispatch_fire;
  assign ready_int     = rst & ~flush & ~rob_full & (~alloc_need | ~fl_empty) &
                         (~held | dispatch_fire);
  assign accept        = in_valid & ready_int;

  // x0 maps to preg 0 and is always ready, regardless of what the RAT returns.
  assign src1_preg = (in_rs1 == '0) ? '0 : rat_rs1_preg;
  assign src2_preg = (in_rs2 == '0) ? '0 : rat_rs2_preg;

  operand_wakeup #(.PHYS_REG_WIDTH(PHYS_REG_WIDTH)) u_cap_rs1 (
    .preg(src1_preg), .rdy_in((in_rs1 == '0) | rat_rs1_rdy),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .rdy_out(cap_rs1_rdy)
  );
  operand_wakeup #(.PHYS_REG_WIDTH(PHYS_REG_WIDTH)) u_cap_rs2 (
    .preg(src2_preg), .rdy_in((in_rs2 == '0) | rat_rs2_rdy),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .rdy_out(cap_rs2_rdy)
  );
  operand_wakeup #(.PHYS_REG_WIDTH(PHYS_REG_WIDTH)) u_held_rs1 (
    .preg(entry_q.prs1), .rdy_in(entry_q.prs1_rdy),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .rdy_out(held_rs1_rdy)
  );
  operand_wakeup #(.PHYS_REG_WIDTH(PHYS_REG_WIDTH)) u_held_rs2 (
    .preg(entry_q.prs2), .rdy_in(entry_q.prs2_rdy),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .rdy_out(held_rs2_rdy)
  );

  always_comb begin
    cap_entry          = '0;
    cap_entry.payload  = in_payload;
    cap_entry.prs1     = src1_preg;
    cap_entry.prs1_rdy = cap_rs1_rdy;
    cap_entry.prs2     = src2_preg;
    cap_entry.prs2_rdy = cap_rs2_rdy;
    cap_entry.prd      = alloc_need ? fl_preg : '0;
    cap_entry.rob_idx  = rob_idx;
    cap_entry.fu       = in_fu;
  end

  // Register view with same-cycle CDB wakeup folded in.
  always_comb begin
    held_view          = entry_q;
    held_view.prs1_rdy = held_rs1_rdy;
    held_view.prs2_rdy = held_rs2_rdy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StEmpty;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StHeld;
      StHeld: begin
        if (flush)                     state_d = StEmpty;
        else if (push_fire && !accept) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    rat_rs1_addr = '0;
    rat_rs2_addr = '0;
    rat_wen      = 1'b0;
    rat_ard      = '0;
    rat_prd      = '0;
    fl_pop       = 1'b0;
    rob_alloc    = 1'b0;
    rob_ard      = '0;
    rob_prd      = '0;
    rs_push      = '0;
    rs_entry     = '0;
    if (rst) begin
      in_ready     = ready_int;
      rat_rs1_addr = in_rs1;
      rat_rs2_addr = in_rs2;
      rs_entry     = held_view;
      if (accept) begin
        rob_alloc = 1'b1;
        rob_ard   = in_rd;
        if (alloc_need) begin
          fl_pop  = 1'b1;
          rat_wen = 1'b1;
          rat_ard = in_rd;
          rat_prd = fl_preg;
          rob_prd = fl_preg;
        end
      end
      if (push_fire) rs_push[entry_q.fu] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        entry_q <= '0;
    else if (accept) entry_q <= cap_entry;
    else if (held)   entry_q <= held_view;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               stall_cycles <= '0;
    else if (in_valid && !ready_int && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_rename_dispatch.sv
// Self-checking bench for rename_dispatch: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_rename_dispatch;
  import rename_dispatch_pkg::*;

  logic clk, rst;
  logic in_valid, in_ready, in_rd_we;
  logic [4:0] in_rs1, in_rs2, in_rd, rat_rs1_addr, rat_rs2_addr, rat_ard, rob_ard;
  logic [1:0] in_fu;
  logic [63:0] in_payload;
  logic [5:0] rat_rs1_preg, rat_rs2_preg, rat_prd, fl_preg, rob_prd, cdb_preg;
  logic rat_rs1_rdy, rat_rs2_rdy, rat_wen, fl_empty, fl_pop, rob_full, rob_alloc;
  logic [4:0] rob_idx;
  logic [3:0] rs_full, rs_push;
  dispatch_entry_t rs_entry;
  logic cdb_valid, flush;
  logic [31:0] stall_cycles;

  rename_dispatch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_fu(in_fu),
    .in_payload(in_payload), .rat_rs1_addr(rat_rs1_addr), .rat_rs2_addr(rat_rs2_addr),
    .rat_rs1_preg(rat_rs1_preg), .rat_rs2_preg(rat_rs2_preg), .rat_rs1_rdy(rat_rs1_rdy),
    .rat_rs2_rdy(rat_rs2_rdy), .rat_wen(rat_wen), .rat_ard(rat_ard), .rat_prd(rat_prd),
    .fl_empty(fl_empty), .fl_preg(fl_preg), .fl_pop(fl_pop), .rob_full(rob_full),
    .rob_alloc(rob_alloc), .rob_ard(rob_ard), .rob_prd(rob_prd), .rob_idx(rob_idx),
    .rs_full(rs_full), .rs_push(rs_push), .rs_entry(rs_entry), .cdb_valid(cdb_valid),
    .cdb_preg(cdb_preg), .flush(flush), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_fu = FuInt;
    in_payload = 64'h0; rat_rs1_preg = 0; rat_rs2_preg = 0; rat_rs1_rdy = 0;
    rat_rs2_rdy = 0; fl_empty = 0; fl_preg = 0; rob_full = 0; rob_idx = 5'd7;
    rs_full = 0; cdb_valid = 0; cdb_preg = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  function automatic dispatch_entry_t mk(input logic [63:0] pl, input logic [5:0] p1,
                                         input logic r1, input logic [5:0] p2, input logic r2,
                                         input logic [5:0] pd, input logic [4:0] ri,
                                         input logic [1:0] fu);
    dispatch_entry_t e;
    e.payload = pl; e.prs1 = p1; e.prs1_rdy = r1; e.prs2 = p2; e.prs2_rdy = r2;
    e.prd = pd; e.rob_idx = ri; e.fu = fu;
    return e;
  endfunction

  typedef struct {
    logic valid; logic [4:0] rs1; logic [4:0] rd; logic we; logic [1:0] fu;
    logic [5:0] rs1_preg; logic fl_empty; logic [5:0] fl_preg; logic rob_full;
    logic [3:0] rs_full; logic flush;
    logic e_ready; logic e_pop; logic e_alloc; logic [5:0] e_rob_prd; logic [3:0] e_push;
  } vec_t;

  vec_t vecs[9];

  // Behavioural model state
  logic            m_held;
  dispatch_entry_t m_ent;
  longint          m_stall;

  initial begin
    rst = 0;
    idle();
    //           vld rs1 rd we fu        p1 fle flp rbf rsf  fl  rdy pop alc prd push
    vecs[0] = '{1, 1, 5, 1, FuInt,    9, 0, 33, 0, 4'h0, 0,  1, 1, 1, 33, 4'h0};
    vecs[1] = '{0, 0, 0, 0, FuInt,    0, 0,  0, 0, 4'h0, 0,  1, 0, 0,  0, 4'h1};
    vecs[2] = '{1, 2, 0, 1, FuMem,    3, 0, 40, 0, 4'h0, 0,  1, 0, 1,  0, 4'h0};
    vecs[3] = '{1, 2, 6, 1, FuInt,    3, 0, 34, 0, 4'h8, 0,  0, 0, 0,  0, 4'h0};
    vecs[4] = '{1, 2, 6, 1, FuInt,    3, 0, 34, 0, 4'h0, 0,  1, 1, 1, 34, 4'h8};
    vecs[5] = '{1, 2, 6, 1, FuInt,    3, 0, 35, 0, 4'h0, 1,  0, 0, 0,  0, 4'h0};
    vecs[6] = '{1, 2, 7, 1, FuInt,    3, 1, 36, 0, 4'h0, 0,  0, 0, 0,  0, 4'h0};
    vecs[7] = '{1, 2, 7, 0, FuBranch, 3, 1, 36, 0, 4'h0, 0,  1, 0, 1,  0, 4'h0};
    vecs[8] = '{1, 2, 8, 1, FuMulDiv, 3, 0, 37, 1, 4'h0, 0,  0, 0, 0,  0, 4'h4};

    do_reset();
    chk("reset_stall", stall_cycles, 32'd0);
    chk("reset_push", rs_push, 4'h0);

    // Directed vector table
    foreach (vecs[i]) begin
      tick();
      idle();
      in_valid = vecs[i].valid; in_rs1 = vecs[i].rs1; in_rd = vecs[i].rd;
      in_rd_we = vecs[i].we; in_fu = vecs[i].fu; rat_rs1_preg = vecs[i].rs1_preg;
      fl_empty = vecs[i].fl_empty; fl_preg = vecs[i].fl_preg; rob_full = vecs[i].rob_full;
      rs_full = vecs[i].rs_full; flush = vecs[i].flush;
      #3;
      chk($sformatf("vec%0d_ready", i), in_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_pop", i), fl_pop, vecs[i].e_pop);
      chk($sformatf("vec%0d_wen", i), rat_wen, vecs[i].e_pop);
      chk($sformatf("vec%0d_alloc", i), rob_alloc, vecs[i].e_alloc);
      chk($sformatf("vec%0d_rob_prd", i), rob_prd, vecs[i].e_rob_prd);
      chk($sformatf("vec%0d_push", i), rs_push, vecs[i].e_push);
    end

    // Rename then push with full entry contents
    do_reset();
    tick();
    in_valid = 1; in_rs1 = 1; rat_rs1_preg = 9; rat_rs1_rdy = 0; in_rs2 = 2;
    rat_rs2_preg = 12; rat_rs2_rdy = 1; in_rd = 5; in_rd_we = 1; in_fu = FuInt;
    fl_preg = 33; rob_idx = 11; in_payload = 64'hDEAD_BEEF_0123_4567;
    #3;
    chk("ren_rs1_addr", rat_rs1_addr, 5'd1);
    chk("ren_rat_ard", rat_ard, 5'd5);
    chk("ren_rat_prd", rat_prd, 6'd33);
    tick();
    idle();
    #3;
    chk("ren_push", rs_push, 4'h1);
    chk("ren_entry", rs_entry, mk(64'hDEAD_BEEF_0123_4567, 9, 0, 12, 1, 33, 11, FuInt));

    // CDB wakeup while held, push later
    do_reset();
    tick();
    in_valid = 1; in_rs1 = 3; rat_rs1_preg = 9; in_fu = FuMulDiv; rs_full = 4'h2;
    tick();
    idle(); rs_full = 4'h2; cdb_valid = 1; cdb_preg = 9;
    #3;
    chk("wake_blocked_push", rs_push, 4'h0);
    tick();
    idle();
    #3;
    chk("wake_push", rs_push, 4'h2);
    chk("wake_entry", rs_entry, mk(64'h0, 9, 1, 0, 1, 0, 7, FuMulDiv));

    // Same-cycle wakeup at push, with back-to-back accept and capture-time wakeup
    do_reset();
    tick();
    in_valid = 1; in_rs1 = 4; rat_rs1_preg = 20; in_fu = FuInt;
    tick();
    in_valid = 1; in_rs1 = 6; rat_rs1_preg = 20; in_fu = FuBranch;
    cdb_valid = 1; cdb_preg = 20;
    #3;
    chk("b2b_ready", in_ready, 1'b1);
    chk("same_cycle_push", rs_push, 4'h1);
    chk("same_cycle_entry", rs_entry, mk(64'h0, 20, 1, 0, 1, 0, 7, FuInt));
    tick();
    idle();
    #3;
    chk("capture_wake_push", rs_push, 4'h4);
    chk("capture_wake_rdy", rs_entry.prs1_rdy, 1'b1);

    // Stall counting on free-list empty, then on ROB full
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      in_valid = 1; in_rd = 7; in_rd_we = 1;
      fl_empty = (k <= 3); rob_full = (k > 3);
      #3;
      chk($sformatf("stall_ready%0d", k), in_ready, 1'b0);
      chk($sformatf("stall_count%0d", k), stall_cycles, 32'(k - 1));
    end
    tick();
    idle();
    #3;
    chk("stall_final", stall_cycles, 32'd6);

    // Flush while held
    do_reset();
    tick();
    in_valid = 1; in_fu = FuInt; rs_full = 4'h1;
    tick();
    rs_full = 4'h0; flush = 1; in_valid = 1;
    #3;
    chk("flush_push", rs_push, 4'h0);
    chk("flush_ready", in_ready, 1'b0);
    chk("flush_alloc", rob_alloc, 1'b0);
    tick();
    idle();
    #3;
    chk("flush_cleared", rs_push, 4'h0);

    // Reset asserted mid-hold
    do_reset();
    tick();
    in_valid = 1; in_rs1 = 3; rat_rs1_preg = 5; in_rd = 4; in_rd_we = 1; fl_preg = 10;
    in_fu = FuMem;
    tick();
    in_rs1 = 9; cdb_valid = 1; cdb_preg = 0; flush = 1;
    rst = 0;
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_pop", {fl_pop, rat_wen, rob_alloc}, 3'b000);
    chk("rst_push", rs_push, 4'h0);
    chk("rst_entry", rs_entry, 91'h0);
    chk("rst_addr", {rat_rs1_addr, rat_rs2_addr, rat_ard, rat_prd, rob_prd}, 27'h0);
    idle();
    @(posedge clk);
    #1 rst = 1;
    #3;
    chk("post_rst_push", rs_push, 4'h0);

    // Randomized run against the model
    do_reset();
    m_held = 0; m_ent = '0; m_stall = 0;
    for (int n = 0; n < 3000; n++) begin
      logic alloc, fire, rdy, acc, r1, r2, w1, w2;
      logic [5:0] p1, p2;
      logic [3:0] e_push;
      dispatch_entry_t e_view;
      tick();
      in_valid = ($urandom_range(0, 3) != 0);
      in_rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_rs2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_rd_we = ($urandom_range(0, 3) != 0);
      in_fu = 2'($urandom_range(0, 3));
      in_payload = {$urandom, $urandom};
      rat_rs1_preg = 6'($urandom_range(0, 15)); rat_rs1_rdy = $urandom_range(0, 1);
      rat_rs2_preg = 6'($urandom_range(0, 15)); rat_rs2_rdy = $urandom_range(0, 1);
      fl_empty = ($urandom_range(0, 9) == 0); fl_preg = 6'($urandom_range(0, 63));
      rob_full = ($urandom_range(0, 9) == 0); rob_idx = 5'($urandom_range(0, 31));
      rs_full = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      cdb_valid = $urandom_range(0, 1); cdb_preg = 6'($urandom_range(0, 15));
      flush = ($urandom_range(0, 19) == 0);
      #3;
      alloc = in_rd_we && in_rd != 0;
      fire = m_held && !rs_full[m_ent.fu];
      rdy = !flush && !rob_full && (!alloc || !fl_empty) && (!m_held || fire);
      acc = in_valid && rdy;
      e_push = (fire && !flush) ? 4'(1 << m_ent.fu) : 4'h0;
      w1 = m_ent.prs1_rdy || (cdb_valid && cdb_preg == m_ent.prs1);
      w2 = m_ent.prs2_rdy || (cdb_valid && cdb_preg == m_ent.prs2);
      e_view = m_ent; e_view.prs1_rdy = w1; e_view.prs2_rdy = w2;
      chk("rnd_ready", in_ready, rdy);
      chk("rnd_pop", {fl_pop, rat_wen}, {2{acc && alloc}});
      chk("rnd_rat_prd", rat_prd, (acc && alloc) ? fl_preg : 6'd0);
      chk("rnd_alloc", rob_alloc, acc);
      chk("rnd_rob_prd", rob_prd, (acc && alloc) ? fl_preg : 6'd0);
      chk("rnd_push", rs_push, e_push);
      chk("rnd_stall", stall_cycles, m_stall[31:0]);
      if (e_push != 0) chk("rnd_entry", rs_entry, e_view);
      // Model update for the coming edge
      p1 = (in_rs1 == 0) ? 6'd0 : rat_rs1_preg;
      p2 = (in_rs2 == 0) ? 6'd0 : rat_rs2_preg;
      r1 = (in_rs1 == 0) || rat_rs1_rdy || (cdb_valid && cdb_preg == p1);
      r2 = (in_rs2 == 0) || rat_rs2_rdy || (cdb_valid && cdb_preg == p2);
      if (in_valid && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (flush) m_held = 0;
      else if (acc) begin
        m_held = 1;
        m_ent = mk(in_payload, p1, r1, p2, r2, alloc ? fl_preg : 6'd0, rob_idx, in_fu);
      end else if (fire) m_held = 0;
      else if (m_held) m_ent = e_view;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_dispatch.md
# rename_dispatch

Front-to-back rename and dispatch stage: the initiator for the backend's rename and dispatch ports. It accepts one decoded uop per cycle and, in the acceptance cycle, does four things: reads source mappings from the RAT, pops a free physical register, writes the new mapping to the RAT, and allocates a ROB entry. The renamed uop is held in a single dispatch register. That register snoops the CDB for operand wakeup and pushes the uop into the selected reservation station when that station has room.

## Interface
Parameters:
- ARCH_REG_WIDTH, 5, architectural register index width
- PHYS_REG_WIDTH, 6, physical register index width
- ROB_IDX_WIDTH, 5, ROB index width
- NUM_RS, 4, reservation stations (0 int, 1 mul/div, 2 branch, 3 mem)
- UOP_WIDTH, 64, opaque decoded payload width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  decode handshake
- in_rs1, in_rs2, in_rd  in  ARCH_REG_WIDTH each  architectural sources and destination
- in_rd_we  in  1  uop writes rd
- in_fu  in  2  target station index
- in_payload  in  UOP_WIDTH  passed through untouched
- rat_rs1_addr, rat_rs2_addr  out  ARCH_REG_WIDTH  combinational RAT read addresses
- rat_rs1_preg, rat_rs2_preg  in  PHYS_REG_WIDTH  current mappings
- rat_rs1_rdy, rat_rs2_rdy  in  1  mapped register already written
- rat_wen, rat_ard, rat_prd  out  1 / ARCH_REG_WIDTH / PHYS_REG_WIDTH  RAT write port
- fl_empty, fl_preg  in  1 / PHYS_REG_WIDTH  free-list head
- fl_pop  out  1  consume the free-list head
- rob_full  in  1  ROB cannot accept an entry
- rob_alloc, rob_ard, rob_prd  out  1 / ARCH_REG_WIDTH / PHYS_REG_WIDTH  ROB allocation
- rob_idx  in  ROB_IDX_WIDTH  index assigned to the current allocation
- rs_full  in  NUM_RS  per-station full flag
- rs_push  out  NUM_RS  one-hot push
- rs_entry  out  dispatch_entry_t  packed entry, common to all stations
- cdb_valid, cdb_preg  in  1 / PHYS_REG_WIDTH  result broadcast
- flush  in  1  branch mispredict recovery
- stall_cycles  out  32  saturating count of cycles with in_valid=1 and in_ready=0

## Operation
- Allocation is needed (alloc_need) when in_rd_we=1 and in_rd≠0.
- in_ready = rst & !flush & !rob_full & (!alloc_need | !fl_empty) & (!held | dispatch_fire).
- dispatch_fire = held & !rs_full[held_fu].
- On accept (in_valid & in_ready):
  - rob_alloc=1.
  - If alloc_need: fl_pop=1, rat_wen=1, rat_ard=in_rd, rat_prd=fl_preg; rob_prd=fl_preg.
  - If not alloc_need: rob_prd=0, no pop, no RAT write.
  - Sources read the pre-write mapping, so a source equal to rd sees the old mapping.
- Source x0 always yields preg 0, ready=1.
- Source readiness at capture = rat_rdy | (cdb_valid & cdb_preg==preg).
- While held, each source whose preg matches cdb_preg with cdb_valid=1 sets its ready bit.
- The dispatch register loads on accept and clears on a dispatch_fire with no simultaneous accept.
- On dispatch_fire, rs_push[held_fu]=1 and rs_entry reflects the register, including any same-cycle CDB wakeup.
- flush clears held, suppresses accept, and forces rs_push=0 in that cycle.
- Only two states: EMPTY (held=0) and HELD (held=1). Transitions:
  - EMPTY→HELD on accept.
  - HELD→HELD on accept with fire, or on no fire.
  - HELD→EMPTY on fire without accept, or on flush.

## Timing
- Rename is combinational in the accept cycle; rs_push occurs no earlier than the next cycle.
- Throughput is one uop per cycle when the target station is not full.
- Reset values: held=0, stall_cycles=0, every registered output 0. All combinational outputs are forced 0 while rst=0.
- A flush asserted while rst=0 has no effect.
- stall_cycles saturates at 32'hFFFF_FFFF.

## Structure
- Shared package: dispatch_entry_t {payload, prs1, prs1_rdy, prs2, prs2_rdy, prd, rob_idx, fu}, plus FU index constants.
- Sub-module: operand_wakeup, which compares one preg against the CDB and returns the updated ready bit. Instantiate four copies: two at capture and two while held.

## Test plan
- rs1=1 (rdy 0, preg 9), rd=5, fl_preg=33 → fl_pop, RAT write 5→33, rob_prd=33; next cycle rs_push[0] with prs1=9, prs1_rdy=0.
- Held entry with prs1=9 not ready; cdb_valid, cdb_preg=9 → entry pushed that or a later cycle with prs1_rdy=1.
- rd=0 with in_rd_we=1 → no fl_pop, no rat_wen, rob_alloc=1, rob_prd=0.
- fl_empty=1 with alloc_need → in_ready=0 and stall_cycles increments each cycle. Same with rob_full=1.
- rs_full[3]=1 with a held mem uop → a second uop is not accepted. Deassert full → push, then the second uop is accepted the same cycle.
- flush while held → no rs_push, held=0, in_ready=0 that cycle. Reset asserted mid-hold → all outputs 0.
